// File: rtl/ser_lanes_param.sv
// Multi-lane word serializer with sync-word training, idle insertion and per-word bit order.
// Optional saturating underrun counter is built when SER_UNDERRUN_CNT_EN is defined.
`timescale 1ns/1ps

module ser_lanes_param #(
    parameter int unsigned N_LANES   = 4,
    parameter int unsigned WORD_W    = 32,
    parameter logic [31:0] SYNC_WORD = 32'h5A5A5A5A,
    parameter logic [31:0] IDLE_WORD = 32'hEAAAAAAA,
    parameter int unsigned SYNC_LEN  = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [N_LANES*WORD_W-1:0]   DATA_IN,
    input  logic [N_LANES-1:0]          DATA_VALID,
    input  logic                        SYNC_REQ,
    input  logic                        LSB_FIRST,
    output logic                        HANDSHAKE,
    output logic [N_LANES-1:0]          SER_OUT,
    output logic                        TRAINING,
    output logic [15:0]                 UNDERRUN_CNT
);

    localparam int unsigned CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [7:0] SYNC_LAST = 8'(SYNC_LEN - 1);
    localparam logic [WORD_W-1:0] SYNC_FIT = WORD_W'(SYNC_WORD);
    localparam logic [WORD_W-1:0] IDLE_FIT = WORD_W'(IDLE_WORD);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [7:0]         sync_cnt;
    logic [WORD_W-1:0]  shreg [N_LANES];
    logic [WORD_W-1:0]  load_word [N_LANES];

    logic load_edge;
    logic burst_done;
    logic take_data;

    // LSB-first words are stored reversed so the outgoing bit is always the register MSB.
    function automatic logic [WORD_W-1:0] bit_order(input logic [WORD_W-1:0] w, input logic lsb);
        logic [WORD_W-1:0] r;
        for (int i = 0; i < WORD_W; i++) begin
            r[i] = w[WORD_W-1-i];
        end
        return lsb ? r : w;
    endfunction

    assign load_edge  = (bit_cnt == LAST_BIT);
    assign burst_done = (state == ST_SYNC) && (sync_cnt == SYNC_LAST);
    assign take_data  = load_edge && !SYNC_REQ && ((state == ST_RUN) || burst_done);

    assign HANDSHAKE = take_data;
    assign TRAINING  = (state == ST_SYNC);

    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            load_word[k] = SYNC_FIT;
            if (take_data) begin
                load_word[k] = DATA_VALID[k] ? DATA_IN[k*WORD_W +: WORD_W] : IDLE_FIT;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            SER_OUT[k] = shreg[k][WORD_W-1];
        end
    end

    // Word framing, lane shift registers and training/run sequencing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_SYNC;
            bit_cnt  <= '0;
            sync_cnt <= '0;
            for (int k = 0; k < N_LANES; k++) begin
                shreg[k] <= SYNC_FIT;
            end
        end else if (load_edge) begin
            bit_cnt <= '0;
            for (int k = 0; k < N_LANES; k++) begin
                shreg[k] <= bit_order(load_word[k], LSB_FIRST);
            end
            case (state)
                ST_SYNC: begin
                    if (burst_done) begin
                        sync_cnt <= '0;
                        if (!SYNC_REQ) begin
                            state <= ST_RUN;
                        end
                    end else begin
                        sync_cnt <= sync_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (SYNC_REQ) begin
                        state    <= ST_SYNC;
                        sync_cnt <= '0;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            for (int k = 0; k < N_LANES; k++) begin
                shreg[k] <= {shreg[k][WORD_W-2:0], 1'b0};
            end
        end
    end

`ifdef SER_UNDERRUN_CNT_EN
    logic [3:0]  miss_cnt;
    logic [15:0] underrun_q;
    logic [16:0] underrun_sum;

    always_comb begin
        miss_cnt = 4'd0;
        for (int k = 0; k < N_LANES; k++) begin
            if (!DATA_VALID[k]) begin
                miss_cnt = miss_cnt + 4'd1;
            end
        end
    end

    assign underrun_sum = {1'b0, underrun_q} + 17'(miss_cnt);

    // Counts every lane-word replaced by the idle word; saturates instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            underrun_q <= 16'h0000;
        end else if (take_data) begin
            underrun_q <= underrun_sum[16] ? 16'hFFFF : underrun_sum[15:0];
        end
    end

    assign UNDERRUN_CNT = underrun_q;
`else
    assign UNDERRUN_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_ser_lanes_param.sv
// Self-checking bench for ser_lanes_param: word-level reference model on a 4x32 instance
// plus an 8x4 instance driven into underrun saturation.
`timescale 1ns/1ps

module tb_ser_lanes_param;

    localparam int unsigned NL = 4;
    localparam int unsigned WW = 32;
    localparam int unsigned SL = 8;
    localparam logic [31:0] SYNC_W = 32'h5A5A5A5A;
    localparam logic [31:0] IDLE_W = 32'hEAAAAAAA;
    localparam int unsigned WAIT_MAX = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [NL*WW-1:0]   data_in;
    logic [NL-1:0]      data_valid;
    logic               sync_req;
    logic               lsb_first;
    logic               handshake;
    logic [NL-1:0]      ser_out;
    logic               training;
    logic [15:0]        underrun_cnt;

    logic               rst_s;
    logic [31:0]        s_data;
    logic [7:0]         s_valid;
    logic               s_sync_req;
    logic               s_lsb;
    logic               s_hs;
    logic [7:0]         s_ser;
    logic               s_train;
    logic [15:0]        s_cnt;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  small_done = 0;

    ser_lanes_param #(
        .N_LANES(NL), .WORD_W(WW), .SYNC_WORD(SYNC_W), .IDLE_WORD(IDLE_W), .SYNC_LEN(SL)
    ) u_dut (
        .CLK(clk), .RST(rst), .DATA_IN(data_in), .DATA_VALID(data_valid),
        .SYNC_REQ(sync_req), .LSB_FIRST(lsb_first), .HANDSHAKE(handshake),
        .SER_OUT(ser_out), .TRAINING(training), .UNDERRUN_CNT(underrun_cnt)
    );

    ser_lanes_param #(
        .N_LANES(8), .WORD_W(4), .SYNC_WORD(SYNC_W), .IDLE_WORD(IDLE_W), .SYNC_LEN(1)
    ) u_small (
        .CLK(clk), .RST(rst_s), .DATA_IN(s_data), .DATA_VALID(s_valid),
        .SYNC_REQ(s_sync_req), .LSB_FIRST(s_lsb), .HANDSHAKE(s_hs),
        .SER_OUT(s_ser), .TRAINING(s_train), .UNDERRUN_CNT(s_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which word each lane is sending, its bit order and position.
    bit           m_valid = 0;
    bit           m_train;
    int           m_left;
    int           m_pos;
    logic [31:0]  m_word [NL];
    bit           m_lsb;
    int unsigned  m_under;

    function automatic logic [15:0] exp_under(input int unsigned u);
`ifdef SER_UNDERRUN_CNT_EN
        return 16'(u);
`else
        return 16'h0000;
`endif
    endfunction

    always @(negedge clk) begin : model
        logic [NL-1:0] eb;
        logic          hs_exp;
        bit            take;
        if (m_valid) begin
            for (int k = 0; k < NL; k++) begin
                eb[k] = m_lsb ? m_word[k][m_pos] : m_word[k][WW-1-m_pos];
            end
            hs_exp = (m_pos == WW-1) && !sync_req && (!m_train || m_left == 1);
            check("ser_out", 64'(ser_out), 64'(eb));
            check("training", 64'(training), 64'(m_train));
            check("handshake", 64'(handshake), 64'(hs_exp));
            check("underrun_cnt", 64'(underrun_cnt), 64'(exp_under(m_under)));
        end
        take = 0;
        if (rst) begin
            m_valid = 1;
            m_train = 1;
            m_left  = SL;
            m_pos   = 0;
            m_lsb   = 0;
            m_under = 0;
            for (int k = 0; k < NL; k++) m_word[k] = SYNC_W;
        end else if (m_valid) begin
            if (m_pos == WW-1) begin
                m_pos = 0;
                m_lsb = lsb_first;
                if (m_train) begin
                    if (m_left == 1) begin
                        if (sync_req) m_left = SL;
                        else begin
                            m_train = 0;
                            take = 1;
                        end
                    end else begin
                        m_left--;
                    end
                end else if (sync_req) begin
                    m_train = 1;
                    m_left  = SL;
                end else begin
                    take = 1;
                end
                for (int k = 0; k < NL; k++) begin
                    if (take) m_word[k] = data_valid[k] ? data_in[k*WW +: WW] : IDLE_W;
                    else      m_word[k] = SYNC_W;
                    if (take && !data_valid[k]) m_under++;
                end
                if (m_under > 65535) m_under = 65535;
            end else begin
                m_pos++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < NL; k++) data_in[k*WW +: WW] = $urandom;
    endtask

    task automatic wait_for(input int pos, input string tag);
        int n = 0;
        while (!(m_valid && !m_train && m_pos == pos) && n < WAIT_MAX) begin
            tick();
            n++;
        end
        check(tag, 64'(n < WAIT_MAX), 64'd1);
    endtask

    // Small instance: every lane always underruns, so the counter climbs 8 per 4-cycle word.
    initial begin : small_run
        int unsigned e_exp;
        s_data = '0; s_valid = '0; s_sync_req = 1'b0; s_lsb = 1'b0;
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        for (int e = 1; e <= 4*8195; e++) begin
            tick();
            e_exp = 8 * (e / 4);
            if (e_exp > 65535) e_exp = 65535;
            if (e == 4) begin
                check("small_idle_first_bit", 64'(s_ser), 64'h00FF);
                check("small_training", 64'(s_train), 64'd0);
            end
            if (e == 5) check("small_idle_second_bit", 64'(s_ser), 64'h0000);
            if (e == 4 || e == 8 || e == 4*8191 || e == 4*8192 || e == 4*8195)
                check("small_underrun", 64'(s_cnt), 64'(exp_under(e_exp)));
        end
        small_done = 1;
    end

    initial begin : main_run
        int n;
        rst = 1'b1; sync_req = 1'b0; lsb_first = 1'b0; data_valid = '1;
        rand_data();
        data_in[31:0] = 32'h12345678;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ser_out", 64'(ser_out), 64'({NL{SYNC_W[31]}}));
        check("reset_training", 64'(training), 64'd1);
        check("reset_handshake", 64'(handshake), 64'd0);
        check("reset_underrun", 64'(underrun_cnt), 64'd0);

        // Training burst then first data word 0x12345678 on lane 0.
        wait_for(0, "wait_first_run");
        rand_data();

        // Partial underrun: lane 2 idle.
        wait_for(WW-1, "wait_partial_valid");
        data_valid = 4'b1011;
        rand_data();
        tick();
        data_valid = '1;

        // Training request in a handshake cycle.
        wait_for(WW-1, "wait_sync_req");
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        wait_for(0, "wait_resume");

        // LSB-first word, order toggled back mid-word.
        wait_for(WW-1, "wait_lsb");
        lsb_first = 1'b1;
        for (int k = 0; k < NL; k++) data_in[k*WW +: WW] = 32'h00000001;
        tick();
        repeat (5) tick();
        lsb_first = 1'b0;

        // Reset pulse mid-word in RUN.
        wait_for(13, "wait_mid_reset");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ser_out", 64'(ser_out), 64'({NL{SYNC_W[31]}}));
        check("midrst_training", 64'(training), 64'd1);
        check("midrst_handshake", 64'(handshake), 64'd0);
        check("midrst_underrun", 64'(underrun_cnt), 64'd0);

        // Randomized traffic with occasional training requests, order flips and resets.
        for (int c = 0; c < 4000; c++) begin
            rand_data();
            data_valid = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '1;
            sync_req   = ($urandom_range(0, 150) == 0);
            if ($urandom_range(0, 40) == 0) lsb_first = ~lsb_first;
            rst        = ($urandom_range(0, 1500) == 0);
            tick();
        end
        rst = 1'b0;
        sync_req = 1'b0;

        n = 0;
        while (!small_done && n < 40000) begin
            tick();
            n++;
        end
        check("small_done", 64'(small_done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
